// File: rtl/dds_voice_scheduler_if.sv
// Note request channel between the MIDI parser (master) and the DDS voice scheduler (slave).
// Signals:
//   note_valid  request valid (master)
//   note_ready  request accepted when note_valid & note_ready (slave)
//   note_on     1 = note-on, 0 = note-off
//   note_key    MIDI key number
//   note_delta  tuning word for note-on; ignored for note-off
interface dds_voice_scheduler_if;
  logic        note_valid;
  logic        note_ready;
  logic        note_on;
  logic [6:0]  note_key;
  logic [31:0] note_delta;

  modport master (
    output note_valid,
    output note_on,
    output note_key,
    output note_delta,
    input  note_ready
  );

  modport slave (
    input  note_valid,
    input  note_on,
    input  note_key,
    input  note_delta,
    output note_ready
  );
endinterface

// File: rtl/dds_voice_scheduler.sv
// DDS voice scheduler.
// Owns the per-voice tuning table feeding a phase-accumulator DDS. Note-on/off requests are
// accepted one at a time, matched or allocated to a voice slot by a sequential scan of the table,
// and committed in a single cycle. Independently, voice_index sweeps 0..NUM_VOICES-1 every clock
// and delta_phase presents that voice's tuning word (0 when idle).
//
// Build option: define VOICE_STEAL_EN to keep a per-voice age and replace the oldest voice when a
// note-on finds no free slot. Without it such a note-on is dropped and drop_pulse is raised.
//
// Ports:
//   clk          clock
//   reset        asynchronous, active-high reset
//   note         request channel (slave modport): note_valid/note_ready/note_on/note_key/note_delta
//   voice_index  voice currently presented to the DDS
//   delta_phase  tuning word of voice_index, 0 if that voice is idle
//   sweep_start  high while voice_index == 0
//   voices_busy  number of active voices
//   drop_pulse   one-cycle pulse when a note-on finds no voice (no-steal build only)
module dds_voice_scheduler #(
  parameter int unsigned NUM_VOICES = 16,
  parameter int unsigned IDX_W      = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  dds_voice_scheduler_if.slave note,
  output logic [IDX_W-1:0]     voice_index,
  output logic [31:0]          delta_phase,
  output logic                 sweep_start,
  output logic [IDX_W:0]       voices_busy,
  output logic                 drop_pulse
);

  localparam int unsigned     AW      = $clog2(NUM_VOICES);
  localparam logic [AW-1:0]   LastIdx = AW'(NUM_VOICES - 1);
  localparam logic [IDX_W:0]  BusyMax = (IDX_W + 1)'(NUM_VOICES);

  typedef enum logic [1:0] {StIdle, StScan, StCommit} state_e;

  // Voice table
  logic        active_q [NUM_VOICES];
  logic [6:0]  key_q    [NUM_VOICES];
  logic [31:0] delta_q  [NUM_VOICES];
`ifdef VOICE_STEAL_EN
  logic [7:0]  age_q    [NUM_VOICES];
`endif

  // Sweep
  logic [AW-1:0] sweep_q, sweep_d;
  logic [31:0]   delta_phase_q;
  logic          sweep_start_q;

  // Request handling
  state_e        state_q, state_d;
  logic          init_q;
  logic          ready;
  logic          accept;
  logic          req_on_q;
  logic [6:0]    req_key_q;
  logic [31:0]   req_delta_q;
  logic [AW-1:0] scan_q;
  logic          match_found_q, free_found_q;
  logic [AW-1:0] match_idx_q, free_idx_q;
`ifdef VOICE_STEAL_EN
  logic [AW-1:0] victim_idx_q;
  logic [7:0]    victim_age_q;
  logic          hit_victim;
`endif
  logic          hit_match, hit_free;

  // Commit controls
  logic          alloc_en, retrig_en, release_en, count_up;
  logic [AW-1:0] alloc_idx;

  logic [IDX_W:0] busy_q;

  // ---------------------------------------------------------------------------------------------
  // Sweep: free-running index; output registers read the table before any same-edge write, so a
  // colliding commit shows up on the next pass of that index.
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    sweep_d = (sweep_q == LastIdx) ? '0 : sweep_q + AW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sweep_q       <= '0;
      delta_phase_q <= '0;
      sweep_start_q <= 1'b1;
    end else begin
      sweep_q       <= sweep_d;
      delta_phase_q <= active_q[sweep_d] ? delta_q[sweep_d] : 32'h0;
      sweep_start_q <= (sweep_d == '0);
    end
  end

  assign voice_index = IDX_W'(sweep_q);
  assign delta_phase = delta_phase_q;
  assign sweep_start = sweep_start_q;

  // ---------------------------------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      init_q  <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (accept) state_d = StScan;
      StScan:   if (scan_q == LastIdx) state_d = StCommit;
      StCommit: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    // init_q holds ready low for the first cycle after reset release
    ready      = (state_q == StIdle) && init_q;
    alloc_en   = 1'b0;
    retrig_en  = 1'b0;
    release_en = 1'b0;
    count_up   = 1'b0;
    drop_pulse = 1'b0;
`ifdef VOICE_STEAL_EN
    alloc_idx  = free_found_q ? free_idx_q : victim_idx_q;
`else
    alloc_idx  = free_idx_q;
`endif
    if (state_q == StCommit) begin
      if (req_on_q) begin
        if (match_found_q) begin
          retrig_en = 1'b1;
        end else if (free_found_q) begin
          alloc_en = 1'b1;
          count_up = 1'b1;
        end else begin
`ifdef VOICE_STEAL_EN
          alloc_en   = 1'b1;
`else
          drop_pulse = 1'b1;
`endif
        end
      end else if (match_found_q) begin
        release_en = 1'b1;
      end
    end
  end

  assign accept          = note.note_valid && ready;
  assign note.note_ready = ready;

  // ---------------------------------------------------------------------------------------------
  // Request latch and scan bookkeeping: one table entry examined per SCAN cycle.
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    hit_match  = active_q[scan_q] && (key_q[scan_q] == req_key_q) && !match_found_q;
    hit_free   = !active_q[scan_q] && !free_found_q;
`ifdef VOICE_STEAL_EN
    // strict compare keeps the lowest index on ties
    hit_victim = age_q[scan_q] > victim_age_q;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_on_q      <= 1'b0;
      req_key_q     <= '0;
      req_delta_q   <= '0;
      scan_q        <= '0;
      match_found_q <= 1'b0;
      free_found_q  <= 1'b0;
      match_idx_q   <= '0;
      free_idx_q    <= '0;
`ifdef VOICE_STEAL_EN
      victim_idx_q  <= '0;
      victim_age_q  <= '0;
`endif
    end else if (accept) begin
      req_on_q      <= note.note_on;
      req_key_q     <= note.note_key;
      req_delta_q   <= note.note_delta;
      scan_q        <= '0;
      match_found_q <= 1'b0;
      free_found_q  <= 1'b0;
      match_idx_q   <= '0;
      free_idx_q    <= '0;
`ifdef VOICE_STEAL_EN
      victim_idx_q  <= '0;
      victim_age_q  <= '0;
`endif
    end else if (state_q == StScan) begin
      scan_q <= scan_q + AW'(1);
      if (hit_match) begin
        match_found_q <= 1'b1;
        match_idx_q   <= scan_q;
      end
      if (hit_free) begin
        free_found_q <= 1'b1;
        free_idx_q   <= scan_q;
      end
`ifdef VOICE_STEAL_EN
      if (hit_victim) begin
        victim_idx_q <= scan_q;
        victim_age_q <= age_q[scan_q];
      end
`endif
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Table write (COMMIT only)
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        active_q[i] <= 1'b0;
        key_q[i]    <= '0;
        delta_q[i]  <= '0;
`ifdef VOICE_STEAL_EN
        age_q[i]    <= '0;
`endif
      end
    end else begin
      if (alloc_en) begin
        active_q[alloc_idx] <= 1'b1;
        key_q[alloc_idx]    <= req_key_q;
        delta_q[alloc_idx]  <= req_delta_q;
      end
      if (retrig_en) begin
        delta_q[match_idx_q] <= req_delta_q;
      end
      if (release_en) begin
        active_q[match_idx_q] <= 1'b0;
        delta_q[match_idx_q]  <= '0;
      end
`ifdef VOICE_STEAL_EN
      // Every allocation ages all other voices; the target's reset below overrides its increment.
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (alloc_en && (age_q[i] != 8'hff)) age_q[i] <= age_q[i] + 8'd1;
      end
      if (alloc_en)  age_q[alloc_idx]   <= '0;
      if (retrig_en) age_q[match_idx_q] <= '0;
`endif
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Active voice count, visible the cycle after COMMIT
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= '0;
    end else if (count_up && (busy_q != BusyMax)) begin
      busy_q <= busy_q + (IDX_W + 1)'(1);
    end else if (release_en && (busy_q != '0)) begin
      busy_q <= busy_q - (IDX_W + 1)'(1);
    end
  end

  assign voices_busy = busy_q;

endmodule
